// File: rtl/core_mul_sched.sv
// Two-lane multiply scheduler: arbitrates, latches operands, tracks one op.
// Define MUL_SCHED_RR_EN for round-robin tie-break (default: lane 0 wins).
module core_mul_sched #(
  parameter int W     = 32,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req,
  output logic [1:0]                 gnt,
  input  logic [1:0][W-1:0]          op_a,
  input  logic [1:0][W-1:0]          op_b,
  input  logic [1:0][2*W-1:0]        op_c,
  input  logic [1:0][2:0]            op_ctl,
  input  logic [1:0][2*TAG_W-1:0]    op_rd,
  input  logic                       flush,
  output logic                       busy,
  output logic                       mul_start,
  output logic [W-1:0]               mul_a,
  output logic [W-1:0]               mul_b,
  output logic [W-1:0]               mul_c_hi,
  output logic [W-1:0]               mul_c_lo,
  output logic                       mul_add,
  output logic                       mul_long,
  output logic                       mul_signed,
  input  logic                       mul_ready,
  input  logic [W-1:0]               mul_q_hi,
  input  logic [W-1:0]               mul_q_lo,
  output logic                       done,
  output logic                       done_lane,
  output logic [2*TAG_W-1:0]         done_rd,
  output logic [2*W-1:0]             done_q,
  output logic                       done_long
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]         state;
  logic [1:0]         pick;
  logic               sel;
  logic               lane_q;
  logic [2*TAG_W-1:0] rd_q;

`ifdef MUL_SCHED_RR_EN
  logic ptr;

  always_comb begin
    pick = req;
    if (req == 2'b11)
      pick = ptr ? 2'b10 : 2'b01;
  end

  // Pointer moves to the lane that did not just win.
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= 1'b0;
    else if (|gnt)
      ptr <= gnt[0];
  end
`else
  always_comb begin
    pick = 2'b00;
    if (req[0])
      pick = 2'b01;
    else if (req[1])
      pick = 2'b10;
  end
`endif

  assign gnt       = (state == IDLE && !flush && !rst) ? pick : 2'b00;
  assign sel       = gnt[1];
  assign busy      = (state != IDLE);
  assign mul_start = (state == ISSUE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_c_hi   <= '0;
      mul_c_lo   <= '0;
      mul_add    <= 1'b0;
      mul_long   <= 1'b0;
      mul_signed <= 1'b0;
      lane_q     <= 1'b0;
      rd_q       <= '0;
      done       <= 1'b0;
      done_lane  <= 1'b0;
      done_rd    <= '0;
      done_q     <= '0;
      done_long  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|gnt) begin
            state      <= ISSUE;
            mul_a      <= op_a[sel];
            mul_b      <= op_b[sel];
            mul_c_hi   <= op_c[sel][2*W-1:W];
            mul_c_lo   <= op_c[sel][W-1:0];
            mul_add    <= op_ctl[sel][2];
            mul_long   <= op_ctl[sel][1];
            mul_signed <= op_ctl[sel][0];
            lane_q     <= sel;
            rd_q       <= op_rd[sel];
          end
        end
        ISSUE: state <= flush ? DRAIN : WAIT;
        WAIT: begin
          if (mul_ready) begin
            state <= IDLE;
            if (!flush) begin
              done      <= 1'b1;
              done_lane <= lane_q;
              done_rd   <= rd_q;
              done_long <= mul_long;
              done_q    <= {mul_long ? mul_q_hi : {W{1'b0}}, mul_q_lo};
            end
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        DRAIN: if (mul_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_mul_sched.sv
// Directed bench for core_mul_sched: grant, latency, arbitration,
// flush, reset and back-to-back issue.
module tb_core_mul_sched;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic [1:0][31:0]  op_a, op_b;
  logic [1:0][63:0]  op_c;
  logic [1:0][2:0]   op_ctl;
  logic [1:0][7:0]   op_rd;
  logic              flush;
  logic              busy, mul_start;
  logic [31:0]       mul_a, mul_b, mul_c_hi, mul_c_lo;
  logic              mul_add, mul_long, mul_signed;
  logic              mul_ready;
  logic [31:0]       mul_q_hi, mul_q_lo;
  logic              done, done_lane, done_long;
  logic [7:0]        done_rd;
  logic [63:0]       done_q;

  int n_checks = 0;
  int n_fail   = 0;

  core_mul_sched #(.W(32), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_ctl(op_ctl),
    .op_rd(op_rd), .flush(flush), .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_c_hi(mul_c_hi), .mul_c_lo(mul_c_lo),
    .mul_add(mul_add), .mul_long(mul_long), .mul_signed(mul_signed),
    .mul_ready(mul_ready), .mul_q_hi(mul_q_hi), .mul_q_lo(mul_q_lo),
    .done(done), .done_lane(done_lane), .done_rd(done_rd),
    .done_q(done_q), .done_long(done_long)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    req = 2'b00; flush = 1'b0; mul_ready = 1'b0;
    op_a = '0; op_b = '0; op_c = '0; op_ctl = '0; op_rd = '0;
    mul_q_hi = '0; mul_q_lo = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1'b1; req = 2'b11;
    #1;
    n_checks++;
    if (gnt !== 2'b00) begin
      n_fail++; $display("FAIL gnt_in_rst: got %b want 00", gnt);
    end
    tick(); tick();
    rst = 1'b0; req = 2'b00;
    #1;
    n_checks++;
    if ({busy, mul_start, done, done_lane, done_long} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 00000",
               {busy, mul_start, done, done_lane, done_long});
    end
    n_checks++;
    if ({done_rd, done_q} !== 72'h0) begin
      n_fail++; $display("FAIL reset_done: got %h want 0", {done_rd, done_q});
    end
    n_checks++;
    if ({mul_a, mul_b, mul_c_hi, mul_c_lo, mul_add, mul_long, mul_signed}
        !== 131'h0) begin
      n_fail++; $display("FAIL reset_mul: got %h want 0", mul_a);
    end
  endtask

  task automatic test_single;
    clear_inputs();
    req = 2'b01; op_a[0] = 32'd7; op_b[0] = 32'd6; op_rd[0] = 8'h03;
    #1;
    n_checks++;
    if (gnt !== 2'b01) begin
      n_fail++; $display("FAIL single_gnt: got %b want 01", gnt);
    end
    tick();
    req = 2'b00;
    n_checks++;
    if ({mul_start, busy, mul_a, mul_b} !== {2'b11, 32'd7, 32'd6}) begin
      n_fail++;
      $display("FAIL single_issue: got start=%b a=%0d b=%0d want 1 7 6",
               mul_start, mul_a, mul_b);
    end
    tick();
    n_checks++;
    if ({mul_start, done} !== 2'b00) begin
      n_fail++; $display("FAIL single_wait: got %b want 00", {mul_start, done});
    end
    mul_ready = 1'b1; mul_q_hi = 32'hDEADBEEF; mul_q_lo = 32'd42;
    tick();
    mul_ready = 1'b0;
    n_checks++;
    if ({done, done_lane, done_long, done_rd} !== {3'b100, 8'h03}) begin
      n_fail++;
      $display("FAIL single_done: got d=%b l=%b lg=%b rd=%h want 1 0 0 03",
               done, done_lane, done_long, done_rd);
    end
    n_checks++;
    if (done_q !== 64'd42) begin
      n_fail++; $display("FAIL single_q: got %h want 2a", done_q);
    end
    tick();
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_fail++; $display("FAIL single_after: got %b want 00", {done, busy});
    end
  endtask

  task automatic test_arb;
    logic [1:0] exp_gnt2;
    logic       exp_lane2;
    logic [7:0] exp_rd2;
`ifdef MUL_SCHED_RR_EN
    exp_gnt2 = 2'b10; exp_lane2 = 1'b1; exp_rd2 = 8'h43;
`else
    exp_gnt2 = 2'b01; exp_lane2 = 1'b0; exp_rd2 = 8'h21;
`endif
    clear_inputs();
    do_reset();
    req = 2'b11;
    op_a[0] = 32'hFFFFFFFE; op_a[1] = 32'hFFFFFFFE;
    op_b[0] = 32'd3;        op_b[1] = 32'd3;
    op_ctl[0] = 3'b011;     op_ctl[1] = 3'b011;
    op_rd[0] = 8'h21;       op_rd[1] = 8'h43;
    #1;
    n_checks++;
    if (gnt !== 2'b01) begin
      n_fail++; $display("FAIL arb_first: got %b want 01", gnt);
    end
    tick();
    n_checks++;
    if ({mul_long, mul_signed, mul_add, mul_a} !== {3'b110, 32'hFFFFFFFE}) begin
      n_fail++;
      $display("FAIL arb_ctl: got %b %h want 110 fffffffe",
               {mul_long, mul_signed, mul_add}, mul_a);
    end
    tick();
    mul_ready = 1'b1; mul_q_hi = 32'hFFFFFFFF; mul_q_lo = 32'hFFFFFFFA;
    tick();
    mul_ready = 1'b0;
    n_checks++;
    if ({done, done_long, done_lane} !== 3'b110) begin
      n_fail++;
      $display("FAIL arb_done1: got %b want 110", {done, done_long, done_lane});
    end
    n_checks++;
    if (done_q !== 64'hFFFFFFFF_FFFFFFFA) begin
      n_fail++; $display("FAIL arb_q: got %h want fffffffffffffffa", done_q);
    end
    n_checks++;
    if (gnt !== exp_gnt2) begin
      n_fail++; $display("FAIL arb_second: got %b want %b", gnt, exp_gnt2);
    end
    tick();
    req = 2'b00;
    tick();
    mul_ready = 1'b1;
    tick();
    mul_ready = 1'b0;
    n_checks++;
    if ({done, done_lane, done_rd} !== {1'b1, exp_lane2, exp_rd2}) begin
      n_fail++;
      $display("FAIL arb_done2: got %b %b %h want 1 %b %h",
               done, done_lane, done_rd, exp_lane2, exp_rd2);
    end
  endtask

  task automatic test_flush;
    clear_inputs();
    req = 2'b01; flush = 1'b1; op_a[0] = 32'd2; op_rd[0] = 8'h07;
    #1;
    n_checks++;
    if (gnt !== 2'b00) begin
      n_fail++; $display("FAIL flush_idle_gnt: got %b want 00", gnt);
    end
    flush = 1'b0;
    tick();
    req = 2'b00;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req = 2'b01;
      #1;
      n_checks++;
      if ({busy, done, gnt} !== 4'b1000) begin
        n_fail++;
        $display("FAIL flush_drain%0d: got %b want 1000", i, {busy, done, gnt});
      end
      req = 2'b00;
      tick();
    end
    mul_ready = 1'b1; mul_q_lo = 32'd77;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL flush_drain_end: got %b want 1", busy);
    end
    tick();
    mul_ready = 1'b0;
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL flush_idle: got %b want 00", {busy, done});
    end
    req = 2'b01;
    tick();
    req = 2'b00;
    tick();
    flush = 1'b1; mul_ready = 1'b1;
    tick();
    flush = 1'b0; mul_ready = 1'b0;
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL flush_wait_rdy: got %b want 00", {busy, done});
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL flush_no_done: got %b want 0", done);
    end
  endtask

  task automatic test_reset_mid;
    clear_inputs();
    req = 2'b01; op_a[0] = 32'd5; op_b[0] = 32'd5; op_rd[0] = 8'h0F;
    op_ctl[0] = 3'b111;
    tick();
    req = 2'b00;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mul_ready = 1'b1; mul_q_lo = 32'd25;
    #1;
    n_checks++;
    if ({busy, mul_start, done, done_lane, done_long, done_rd, done_q}
        !== 77'h0) begin
      n_fail++; $display("FAIL rstmid_out: got busy=%b done=%b want 0 0", busy, done);
    end
    n_checks++;
    if ({mul_a, mul_b, mul_c_hi, mul_c_lo, mul_add, mul_long, mul_signed}
        !== 131'h0) begin
      n_fail++; $display("FAIL rstmid_mul: got a=%h want 0", mul_a);
    end
    tick();
    mul_ready = 1'b0;
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_nodone: got %b want 00", {done, busy});
    end
    req = 2'b10; op_a[1] = 32'd9; op_b[1] = 32'd4; op_rd[1] = 8'h5A;
    op_ctl[1] = 3'b100;
    #1;
    n_checks++;
    if (gnt !== 2'b10) begin
      n_fail++; $display("FAIL rstmid_gnt: got %b want 10", gnt);
    end
    tick();
    req = 2'b00;
    n_checks++;
    if ({mul_start, mul_add, mul_long, mul_a} !== {3'b110, 32'd9}) begin
      n_fail++;
      $display("FAIL rstmid_issue: got %b a=%0d want 110 9",
               {mul_start, mul_add, mul_long}, mul_a);
    end
    tick();
    mul_ready = 1'b1; mul_q_hi = 32'h1; mul_q_lo = 32'd36;
    tick();
    mul_ready = 1'b0;
    n_checks++;
    if ({done, done_lane, done_rd, done_q} !== {2'b11, 8'h5A, 64'd36}) begin
      n_fail++;
      $display("FAIL rstmid_done: got %b %b %h %h want 1 1 5a 24",
               done, done_lane, done_rd, done_q);
    end
  endtask

  task automatic test_back_to_back;
    clear_inputs();
    tick();
    req = 2'b01; op_a[0] = 32'd3; op_b[0] = 32'd4; op_rd[0] = 8'h11;
    tick();
    req = 2'b00;
    mul_ready = 1'b1; mul_q_lo = 32'd99;
    tick();
    mul_q_lo = 32'd12;
    tick();
    mul_ready = 1'b0;
    n_checks++;
    if ({done, done_q} !== {1'b1, 64'd12}) begin
      n_fail++; $display("FAIL b2b_done: got %b %h want 1 c", done, done_q);
    end
    req = 2'b01; op_a[0] = 32'd8;
    #1;
    n_checks++;
    if (gnt !== 2'b01) begin
      n_fail++; $display("FAIL b2b_gnt: got %b want 01", gnt);
    end
    tick();
    req = 2'b00;
    n_checks++;
    if ({mul_start, done, mul_a} !== {2'b10, 32'd8}) begin
      n_fail++;
      $display("FAIL b2b_start: got %b a=%0d want 10 8", {mul_start, done}, mul_a);
    end
    tick();
    mul_ready = 1'b1; mul_q_lo = 32'd32;
    tick();
    mul_ready = 1'b0;
    n_checks++;
    if ({done, done_q} !== {1'b1, 64'd32}) begin
      n_fail++; $display("FAIL b2b_done2: got %b %h want 1 20", done, done_q);
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_single();
    test_arb();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
